// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small write FIFO feeding a registered serial framer.
// A frame leaves TX_OUT one cycle after the write edge; Data_Ready drops only while the FIFO is full.

// Generic FIFO with show-ahead head. A write is accepted only when not full, regardless of a same-edge pop.
module uart_tx_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    input  logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign wr_rdy = (count != CW'(DEPTH));
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RST_ASYN,
    input  logic [DATA_WIDTH-1:0]           P_DATA,
    input  logic                            Data_Valid,
    output logic                            Data_Ready,
    input  logic                            PAR_EN,
    input  logic                            PAR_TYP,
    input  logic                            STOP2,
    input  logic [PRESCALE_WIDTH-1:0]       PRESCALE,
    output logic                            TX_OUT,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int PW    = PRESCALE_WIDTH;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          timer, timer_nxt;
    logic [PW-1:0]          presc_q, presc_nxt;
    logic [BIT_W-1:0]       idx, idx_nxt;
    logic [DATA_WIDTH-1:0]  sr, sr_nxt;
    logic                   par_en_q, par_en_nxt;
    logic                   par_bit_q, par_bit_nxt;
    logic                   stop2_q, stop2_nxt;
    logic                   tx_q, tx_nxt;
    logic                   busy_q;
    logic                   start_frame;
    logic                   bit_done;
    logic [DATA_WIDTH-1:0]  head;

    uart_tx_fifo_buf #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST_ASYN),
        .wr_vld (Data_Valid),
        .wr_dat (P_DATA),
        .wr_rdy (Data_Ready),
        .rd_vld (start_frame),
        .rd_dat (head),
        .count  (FIFO_COUNT)
    );

    assign bit_done = (timer == presc_q - PW'(1));
    assign TX_OUT   = tx_q;
    assign busy     = busy_q;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        presc_nxt   = presc_q;
        idx_nxt     = idx;
        sr_nxt      = sr;
        par_en_nxt  = par_en_q;
        par_bit_nxt = par_bit_q;
        stop2_nxt   = stop2_q;
        start_frame = 1'b0;
        tx_nxt      = 1'b1;

        if (state != IDLE) timer_nxt = bit_done ? '0 : timer + PW'(1);

        case (state)
            IDLE: begin
                if (FIFO_COUNT != '0) start_frame = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    sr_nxt = sr >> 1;
                    if (idx == BIT_W'(DATA_WIDTH - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_nxt = idx + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                    idx_nxt   = '0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (idx == {{(BIT_W-1){1'b0}}, stop2_q}) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (FIFO_COUNT != '0) start_frame = 1'b1;
                        else                  state_nxt   = IDLE;
                    end else begin
                        idx_nxt = idx + BIT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame settings are captured only here so mid-frame input changes are ignored.
        if (start_frame) begin
            state_nxt   = START;
            timer_nxt   = '0;
            idx_nxt     = '0;
            sr_nxt      = head;
            par_en_nxt  = PAR_EN;
            par_bit_nxt = (^head) ^ PAR_TYP;
            stop2_nxt   = STOP2;
            presc_nxt   = (PRESCALE == '0) ? PW'(1) : PRESCALE;
        end

        case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sr_nxt[0];
            PARITY:  tx_nxt = par_bit_nxt;
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_ASYN) begin
        if (RST_ASYN) begin
            state     <= IDLE;
            timer     <= '0;
            presc_q   <= PW'(1);
            idx       <= '0;
            sr        <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            presc_q   <= presc_nxt;
            idx       <= idx_nxt;
            sr        <= sr_nxt;
            par_en_q  <= par_en_nxt;
            par_bit_q <= par_bit_nxt;
            stop2_q   <= stop2_nxt;
            tx_q      <= tx_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues hand-written frame patterns,
// a line monitor checks every cycle of every bit against them.
module tb_uart_tx_fifo;
    logic        CLK;
    logic        RST_ASYN;
    logic [7:0]  P_DATA;
    logic        Data_Valid;
    logic        Data_Ready;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        STOP2;
    logic [15:0] PRESCALE;
    logic        TX_OUT;
    logic        busy;
    logic [2:0]  FIFO_COUNT;

    uart_tx_fifo #(
        .DATA_WIDTH     (8),
        .FIFO_DEPTH     (4),
        .PRESCALE_WIDTH (16)
    ) dut (
        .CLK        (CLK),
        .RST_ASYN   (RST_ASYN),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Data_Ready (Data_Ready),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .FIFO_COUNT (FIFO_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          presc;
    } frm_t;

    frm_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Pattern string lists line levels in transmission order, leftmost first.
    function automatic logic [15:0] pat(input string s);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[i] = (s[i] == 8'h31);
        return v;
    endfunction

    task automatic expect_frame(input string s, input int presc);
        frm_t f;
        f.bits  = pat(s);
        f.nbits = s.len();
        f.presc = presc;
        exp_q.push_back(f);
    endtask

    // Line monitor
    frm_t cur;
    bit   mon_act = 1'b0;
    int   bi, ci, berr;
    int   fno = 0;

    always @(negedge CLK) begin
        if (RST_ASYN) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && TX_OUT == 1'b0) begin
                chk("frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    mon_act = 1'b1;
                    bi = 0; ci = 0; berr = 0;
                end
            end
            if (mon_act) begin
                if (TX_OUT !== cur.bits[bi] || busy !== 1'b1) berr++;
                ci++;
                if (ci == cur.presc) begin
                    chk($sformatf("frame%0d_bit%0d_bad_cycles", fno, bi), berr, 0);
                    bi++; ci = 0; berr = 0;
                    if (bi == cur.nbits) begin
                        mon_act = 1'b0;
                        fno++;
                    end
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [7:0] d, output logic rdy);
        P_DATA     = d;
        Data_Valid = 1'b1;
        rdy        = Data_Ready;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_n, input bit toggle);
        int n;
        bit seen;
        bit done;
        n = 0; seen = 0; done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge CLK);
            if (busy) begin
                n++;
                seen = 1;
                if (toggle) begin
                    P_DATA   = ~P_DATA;
                    PAR_EN   = ~PAR_EN;
                    PAR_TYP  = ~PAR_TYP;
                    STOP2    = ~STOP2;
                    PRESCALE = PRESCALE + 16'd3;
                end
            end else if (seen) begin
                done = 1;
            end
        end
        chk({name, "_busy_cycles"}, n, exp_n);
        chk({name, "_idle_tx"}, TX_OUT, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [7:0] bytes6 [6];
    string      pats5  [5];
    logic       rdy;
    int         bad;

    initial begin
        bytes6 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        pats5  = '{"0100000101", "0010000101", "0110000101", "0001000101", "0101000101"};
        RST_ASYN = 1'b1; P_DATA = '0; Data_Valid = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 16'd4;
        #3;
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", Data_Ready, 1);
        chk("rst_count", FIFO_COUNT, 0);
        repeat (2) @(negedge CLK);
        RST_ASYN = 1'b0;
        repeat (2) @(negedge CLK);

        // Single 0xD9, no parity, one stop bit
        expect_frame("0100110111", 4);
        wr(8'hD9, rdy);
        chk("d9_rdy", rdy, 1);
        chk("d9_tx_before_start", TX_OUT, 1);
        chk("d9_count", FIFO_COUNT, 1);
        @(negedge CLK);
        chk("d9_start_latency", TX_OUT, 0);
        chk("d9_count_popped", FIFO_COUNT, 0);
        wait_idle("d9", 39, 0);

        // Even then odd parity, back to back
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        expect_frame("01001101111", 4);
        expect_frame("01001101101", 4);
        wr(8'hD9, rdy);
        wr(8'hD9, rdy);
        chk("par_push_pop_count", FIFO_COUNT, 1);
        PAR_TYP = 1'b1;
        wait_idle("par", 87, 0);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);

        // Six writes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_frame(pats5[i], 4);
            wr(bytes6[i], rdy);
            if (i < 5) chk($sformatf("burst_rdy%0d", i), rdy, 1);
            else       chk("burst_full_rdy", rdy, 0);
        end
        chk("burst_peak_count", FIFO_COUNT, 4);
        chk("burst_full_ready", Data_Ready, 0);
        wait_idle("burst", 195, 0);

        // Two stop bits, PRESCALE 1 and then 0
        STOP2 = 1'b1; PRESCALE = 16'd1;
        expect_frame("00101101011", 1);
        wr(8'h5A, rdy);
        wait_idle("stop2_p1", 11, 0);
        PRESCALE = 16'd0;
        expect_frame("00101101011", 1);
        wr(8'h5A, rdy);
        wait_idle("stop2_p0", 11, 0);
        STOP2 = 1'b0; PRESCALE = 16'd4;
        repeat (3) @(negedge CLK);

        // Reset during data bit 3 of the first of three queued frames
        expect_frame("0111111111", 4);
        expect_frame("0000000001", 4);
        expect_frame("0101010101", 4);
        wr(8'hFF, rdy);
        wr(8'h00, rdy);
        wr(8'h55, rdy);
        repeat (16) @(negedge CLK);
        RST_ASYN = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_tx", TX_OUT, 1);
        chk("abort_busy", busy, 0);
        chk("abort_count", FIFO_COUNT, 0);
        chk("abort_rdy", Data_Ready, 1);
        @(negedge CLK);
        RST_ASYN = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge CLK);
            if (busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
        end
        chk("abort_no_resume", bad, 0);

        // Write right after reset release, then toggle inputs mid-frame
        RST_ASYN = 1'b1;
        @(negedge CLK);
        RST_ASYN = 1'b0;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 16'd4;
        expect_frame("00011110001", 4);
        wr(8'h3C, rdy);
        chk("post_rst_rdy", rdy, 1);
        chk("post_rst_count", FIFO_COUNT, 1);
        wait_idle("toggle", 44, 1);

        repeat (5) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        chk("frames_seen", fno, 11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
